mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter that shares the processor's single multi-cycle memory between the instruction-fetch side (I-side) and the data/memory-stage side (D-side). It sits between the fetch and memory stages and the memory model: it accepts one request at a time, sequences it through the memory's accept/stall/done protocol, and returns completion with read data to the owner. D-side wins ties by default; a streak counter bounds I-side starvation, and a watchdog converts a lost `mem_done` into an error completion.

## Interface
- `STARVE_LIMIT`, 4: consecutive D-side grants while `i_req` is waiting before the I-side is forced ahead.
- `TIMEOUT`, 64: WAIT-state cycles without `mem_done` before an error completion.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `i_req`  in  1  I-side read request; held until `i_done`.
- `i_addr`  in  16  I-side address; stable while `i_req` high.
- `i_grant`  out  1  one-cycle pulse: I-side request latched.
- `i_done`  out  1  one-cycle pulse: I-side transaction complete.
- `d_req`  in  1  D-side request; held until `d_done`.
- `d_wr`  in  1  D-side write (1) / read (0).
- `d_addr`  in  16  D-side address.
- `d_wdata`  in  16  D-side write data.
- `d_grant`  out  1  one-cycle pulse: D-side request latched.
- `d_done`  out  1  one-cycle pulse: D-side transaction complete.
- `rdata`  out  16  read data; valid with `i_done`/`d_done`, held until next done.
- `err`  out  1  qualifies current done: watchdog expired.
- `mem_en`  out  1  memory access request.
- `mem_wr`  out  1  write enable to memory.
- `mem_addr`  out  16  memory address.
- `mem_wdata`  out  16  memory write data.
- `mem_stall`  in  1  memory refuses the access this cycle.
- `mem_done`  in  1  one-cycle pulse: access complete; `mem_rdata` valid.
- `mem_rdata`  in  16  memory read data.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: arbitrate on sampled `i_req`/`d_req`. Only one -> that side. Both -> D-side, unless `streak == STARVE_LIMIT`, then I-side. Winner's addr/wr/wdata latched into owner registers; -> ISSUE. Neither -> stay. `mem_done` in IDLE ignored.
- ISSUE: `mem_en`=1, `mem_addr`/`mem_wr`/`mem_wdata` from owner registers (`mem_wr`=0 for I-side). Owner's grant pulses on the first ISSUE cycle only. `mem_stall`=1 -> stay ISSUE, outputs unchanged; `mem_stall`=0 -> WAIT. `mem_done` in ISSUE ignored.
- WAIT: `mem_en`=0. Watchdog counts from 0. `mem_done` -> capture `mem_rdata` (reads; writes leave `rdata` unchanged), `err`=0, -> DONE. Watchdog reaches TIMEOUT -> `rdata`=0, `err`=1, -> DONE.
- DONE: owner's done=1 for exactly one cycle, `err` valid; -> IDLE. The requester drops `req` in the following cycle, so IDLE never re-serves a completed request.
- Streak: at D-side grant with `i_req`=1 -> increment, saturating at STARVE_LIMIT; at D-side grant with `i_req`=0, or any I-side grant -> 0.
- Requester dropping `req` before grant: ignored. After grant: the transaction still completes and done still pulses.
- Watchdog: 7-bit counter, cleared on entry to WAIT.

## Timing
- Reset (asserted): state IDLE, streak 0, watchdog 0, all outputs 0 including `rdata`. Asserting reset mid-transaction aborts it; a late `mem_done` after reset is ignored in IDLE.
- Latency: request seen in IDLE at cycle 0 -> grant and `mem_en` in cycle 1. If accepted, WAIT begins in cycle 2. `mem_done` in cycle t -> done in t+1, IDLE in t+2.
- With a fixed memory latency of 4 (done 4 cycles after accept) and no stall, req in cycle 0 -> done in cycle 6; next grant no earlier than cycle 8.
- All outputs are registered or decoded from state/owner registers; there is no combinational path from `*_req` to `*_grant`.

## Test plan
- Single I-side read, `i_addr`=0x0040, memory latency 4, returns 0xBEEF -> `i_grant` in cycle 1, `i_done` in cycle 6 with `rdata`=0xBEEF and `err`=0; `d_grant`/`d_done` never asserted.
- Simultaneous `i_req` and D-side write (`d_addr`=0x1000, `d_wdata`=0x1234) -> D served first (`mem_wr`=1, `mem_wdata`=0x1234); I granted in the IDLE that follows `d_done`.
- `d_req` held continuously, `i_req` held, STARVE_LIMIT=4 -> exactly 4 D grants, then I grant; streak returns to 0 and D is served next.
- `mem_stall` high for 3 cycles in ISSUE -> `mem_en`/`mem_addr` stable for 4 cycles, grant pulses once, done delayed by 3 cycles.
- No `mem_done` -> done after 64 WAIT cycles with `err`=1 and `rdata`=0x0000; a later stray `mem_done` is ignored.
- Reset asserted in WAIT -> all outputs 0 immediately; after release, a new request completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle memory between the I-side and D-side. The D-side wins ties,
// the I-side is forced ahead after a bounded streak, and a watchdog covers a lost mem_done.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_grant,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_grant,
    output logic        d_done,
    output logic [15:0] rdata,
    output logic        err,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_stall,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    state_t        state_q, state_d;
    logic          own_d_q, own_d_d;
    logic          wr_q, wr_d;
    logic          first_q, first_d;
    logic          err_q, err_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   rdata_q, rdata_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [6:0]    wdog_q, wdog_d;
    logic          pick_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            own_d_q  <= 1'b0;
            wr_q     <= 1'b0;
            first_q  <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            streak_q <= '0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            own_d_q  <= own_d_d;
            wr_q     <= wr_d;
            first_q  <= first_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            streak_q <= streak_d;
            wdog_q   <= wdog_d;
        end
    end

    // D-side wins unless the I-side has already been passed over STARVE_LIMIT times.
    assign pick_d = d_req && !(i_req && (streak_q == SW'(STARVE_LIMIT)));

    always_comb begin
        state_d  = state_q;
        own_d_d  = own_d_q;
        wr_d     = wr_q;
        first_d  = 1'b0;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        streak_d = streak_q;
        wdog_d   = wdog_q;
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    own_d_d  = 1'b1;
                    wr_d     = d_wr;
                    addr_d   = d_addr;
                    wdata_d  = d_wdata;
                    first_d  = 1'b1;
                    state_d  = ISSUE;
                    if (!i_req)
                        streak_d = '0;
                    else if (streak_q != SW'(STARVE_LIMIT))
                        streak_d = streak_q + SW'(1);
                end else if (i_req) begin
                    own_d_d  = 1'b0;
                    wr_d     = 1'b0;
                    addr_d   = i_addr;
                    wdata_d  = '0;
                    first_d  = 1'b1;
                    streak_d = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (!mem_stall) begin
                    wdog_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_done) begin
                    if (!wr_q)
                        rdata_d = mem_rdata;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (wdog_q == 7'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wdog_d = wdog_q + 7'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_en    = (state_q == ISSUE);
    assign mem_wr    = mem_en && wr_q;
    assign mem_addr  = mem_en ? addr_q : 16'h0000;
    assign mem_wdata = mem_wr ? wdata_q : 16'h0000;
    assign i_grant   = mem_en && first_q && !own_d_q;
    assign d_grant   = mem_en && first_q && own_d_q;
    assign i_done    = (state_q == DONE) && !own_d_q;
    assign d_done    = (state_q == DONE) && own_d_q;
    assign err       = (state_q == DONE) && err_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small latency-programmable memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr, mem_stall, mem_done;
    logic        mdl_done, stray_done;
    logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_grant, i_done, d_grant, d_done, err, mem_en, mem_wr, busy;
    logic [15:0] rdata, mem_addr, mem_wdata;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          mem_lat = 4;
    bit          mem_drop = 1'b0;
    logic [15:0] mem_rval = 16'h0000;

    int          ig_c, id_c, dg_c, dd_c, ig_n, id_n, dg_n, dd_n, en_n;
    logic [15:0] i_rd, d_rd, en_addr, en_wdata;
    logic        i_er, d_er, en_wr;
    bit          addr_moved;
    bit          seq[$];
    logic [5:0]  order;

    assign mem_done = mdl_done | stray_done;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(d_grant), .d_done(d_done),
        .rdata(rdata), .err(err),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_stall(mem_stall), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // Memory: pulses mdl_done mem_lat cycles after the accepting ISSUE cycle.
    initial begin
        int cnt;
        cnt       = -1;
        mdl_done  = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (mem_en && !mem_stall && !mem_drop) cnt = mem_lat;
            @(posedge clk);
            #1;
            mdl_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mdl_done  = 1'b1;
                    mem_rdata = mem_rval;
                    cnt       = -1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        ig_c = -1; id_c = -1; dg_c = -1; dd_c = -1;
        ig_n = 0;  id_n = 0;  dg_n = 0;  dd_n = 0; en_n = 0;
        i_rd = '0; d_rd = '0; i_er = 1'b0; d_er = 1'b0;
        en_addr = '0; en_wdata = '0; en_wr = 1'b0;
        addr_moved = 1'b0;
        seq.delete();
    endtask

    // Cycle 0 is the cycle in which the caller raised the request(s).
    task automatic run(input int n, input bit hold, input int stall_n);
        bit drop_i, drop_d;
        for (int c = 0; c < n; c++) begin
            drop_i = 1'b0;
            drop_d = 1'b0;
            @(negedge clk);
            if (i_grant) begin seq.push_back(1'b0); if (ig_c < 0) ig_c = c; ig_n++; end
            if (d_grant) begin seq.push_back(1'b1); if (dg_c < 0) dg_c = c; dg_n++; end
            if (i_done) begin if (id_c < 0) id_c = c; id_n++; i_rd = rdata; i_er = err; drop_i = !hold; end
            if (d_done) begin if (dd_c < 0) dd_c = c; dd_n++; d_rd = rdata; d_er = err; drop_d = !hold; end
            if (mem_en) begin
                if (en_n == 0) begin
                    en_addr = mem_addr; en_wr = mem_wr; en_wdata = mem_wdata;
                end else if (mem_addr !== en_addr) begin
                    addr_moved = 1'b1;
                end
                en_n++;
            end
            @(posedge clk);
            #1;
            if (drop_i) i_req = 1'b0;
            if (drop_d) begin d_req = 1'b0; d_wr = 1'b0; end
            mem_stall = (c + 1 <= stall_n);
        end
    endtask

    initial begin
        rst = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; mem_stall = 1'b0; stray_done = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        clr();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_outs", {i_grant, i_done, d_grant, d_done, err, mem_en, mem_wr}, 0);
        check("rst_rdata", rdata, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // single I-side read
        clr(); mem_lat = 4; mem_rval = 16'hBEEF;
        i_req = 1'b1; i_addr = 16'h0040;
        run(10, 1'b0, 0);
        check("t1_igrant_cyc", ig_c, 1);
        check("t1_idone_cyc", id_c, 6);
        check("t1_rdata", i_rd, 16'hBEEF);
        check("t1_err", i_er, 0);
        check("t1_d_quiet", dg_n + dd_n, 0);
        check("t1_en_cycles", en_n, 1);
        check("t1_mem_addr", en_addr, 16'h0040);
        check("t1_mem_wr", en_wr, 0);

        // tie: D write first, I right after
        clr(); mem_lat = 2; mem_rval = 16'h5A5A;
        i_req = 1'b1; i_addr = 16'h0044;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h1000; d_wdata = 16'h1234;
        run(14, 1'b0, 0);
        check("t2_grants", seq.size(), 2);
        check("t2_first_is_d", seq[0], 1);
        check("t2_second_is_i", seq[1], 0);
        check("t2_mem_wr", en_wr, 1);
        check("t2_mem_addr", en_addr, 16'h1000);
        check("t2_mem_wdata", en_wdata, 16'h1234);
        check("t2_ddone_cyc", dd_c, 4);
        check("t2_write_keeps_rdata", d_rd, 16'hBEEF);
        check("t2_igrant_cyc", ig_c, 6);
        check("t2_idone_cyc", id_c, 9);
        check("t2_i_rdata", i_rd, 16'h5A5A);

        // starvation bound with both sides held
        clr(); mem_lat = 1; mem_rval = 16'h0001;
        i_req = 1'b1; i_addr = 16'h0048;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h2000;
        run(30, 1'b1, 0);
        order = '0;
        for (int k = 0; k < 6; k++) order[5-k] = (k < seq.size()) ? seq[k] : 1'b0;
        check("t3_order_DDDDID", order, 6'b111101);
        check("t3_igrant_cyc", ig_c, 17);
        check("t3_i_grants", ig_n, 1);
        i_req = 1'b0; d_req = 1'b0;
        run(8, 1'b0, 0);
        check("t3_flushed", busy, 0);

        // three stalled ISSUE cycles
        clr(); mem_lat = 4; mem_rval = 16'h7777;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0300; mem_stall = 1'b1;
        run(14, 1'b0, 3);
        check("t4_grant_once", dg_n, 1);
        check("t4_dgrant_cyc", dg_c, 1);
        check("t4_en_cycles", en_n, 4);
        check("t4_addr_stable", addr_moved, 0);
        check("t4_ddone_cyc", dd_c, 9);
        check("t4_rdata", d_rd, 16'h7777);

        // reset while waiting on memory
        clr(); mem_lat = 10; mem_rval = 16'h1111;
        i_req = 1'b1; i_addr = 16'h0080;
        run(4, 1'b0, 0);
        check("t5_in_wait", busy, 1);
        rst = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_outs", {i_grant, i_done, d_grant, d_done, err, mem_en, mem_wr}, 0);
        check("t5_rst_rdata", rdata, 0);
        i_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        clr();
        run(12, 1'b0, 0);
        check("t5_late_done_ignored", {busy, rdata}, 0);
        check("t5_no_done", id_n + dd_n, 0);
        clr(); mem_lat = 2; mem_rval = 16'h2222;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0300;
        run(8, 1'b0, 0);
        check("t5_after_ddone_cyc", dd_c, 4);
        check("t5_after_rdata", d_rd, 16'h2222);
        check("t5_after_err", d_er, 0);

        // watchdog expiry, then a stray mem_done in IDLE
        clr(); mem_drop = 1'b1; mem_rval = 16'h3333;
        i_req = 1'b1; i_addr = 16'h0050;
        run(70, 1'b0, 0);
        check("t6_idone_cyc", id_c, 66);
        check("t6_err", i_er, 1);
        check("t6_rdata_zero", i_rd, 16'h0000);
        clr();
        stray_done = 1'b1;
        run(1, 1'b0, 0);
        stray_done = 1'b0;
        run(3, 1'b0, 0);
        check("t6_stray_no_done", id_n + dd_n, 0);
        check("t6_stray_rdata", rdata, 16'h0000);
        check("t6_stray_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
